// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared depth default, lock FSM states and port indices for dmem_arbiter.
package dmem_pkg;
  localparam int DMEM_DEPTH = 256;
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_t;
  function automatic logic in_range(input logic [31:0] addr, input int depth);
    return {2'b00, addr[31:2]} < 32'(depth);
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin grant; last_q holds the most recent winner.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);
  logic last_q, last_d;
  always_comb begin
    gnt0_o = req0_i & (~req1_i | last_q);
    gnt1_o = req1_i & (~req0_i | ~last_q);
    last_d = gnt0_o ? PORT_CORE : gnt1_o ? PORT_AUX : last_q;
  end
  always_ff @(posedge clk) last_q <= rst ? PORT_AUX : last_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the data memory between core (port 0) and aux (port 1).
// Optional grant locking is enabled with DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        lock0_i,
  input  logic        lock1_i,
`endif
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  arb_state_t state_q, state_d;
  logic lk0, lk1, own0, own1, m_req0, m_req1, any, sel, we, ok;
  logic [31:0] addr, wdata;
  logic rsp_valid_q, rsp_valid_d, rsp_port_q, rsp_port_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  // Ownership is released as soon as the owner drops req or lock; that cycle arbitrates normally.
  always_comb begin
`ifdef DMEM_ARB_LOCK_EN
    lk0 = lock0_i;
    lk1 = lock1_i;
`else
    lk0 = 1'b0;
    lk1 = 1'b0;
`endif
    own0 = (state_q == OWN0) & req0_i & lk0;
    own1 = (state_q == OWN1) & req1_i & lk1;
    m_req0 = req0_i & ~rst & ~own1;
    m_req1 = req1_i & ~rst & ~own0;
  end
  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req0_i(m_req0),
    .req1_i(m_req1),
    .gnt0_o(gnt0_o),
    .gnt1_o(gnt1_o)
  );
  always_comb begin
    any = gnt0_o | gnt1_o;
    sel = gnt1_o;
    we = sel ? we1_i : we0_i;
    addr = any ? (sel ? addr1_i : addr0_i) : '0;
    wdata = any ? (sel ? wdata1_i : wdata0_i) : '0;
    ok = in_range(addr, DEPTH);
    mem_read_o = any & ~we & ok;
    mem_write_o = any & we & ok;
    mem_addr_o = addr;
    mem_wdata_o = wdata;
    rsp_valid_d = any;
    rsp_port_d = sel;
    rsp_err_d = any & ~ok;
    rsp_data_d = mem_read_o ? mem_rdata_i : '0;
    state_d = (gnt0_o & lk0) ? OWN0 : (gnt1_o & lk1) ? OWN1 : IDLE;
    rvalid0_o = rsp_valid_q & (rsp_port_q == PORT_CORE) & ~rst;
    rvalid1_o = rsp_valid_q & (rsp_port_q == PORT_AUX) & ~rst;
    rdata0_o = rvalid0_o ? rsp_data_q : '0;
    rdata1_o = rvalid1_o ? rsp_data_q : '0;
    err0_o = rvalid0_o & rsp_err_q;
    err1_o = rvalid1_o & rsp_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_port_q <= PORT_CORE;
      rsp_err_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q <= rsp_port_d;
      rsp_err_q <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, reference-model random traffic and lock sequence for dmem_arbiter.
module tb_dmem_arbiter;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  logic clk, rst, mem_clr;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  int n_chk = 0, n_fail = 0;
  logic chk_model;
  int mlast, mw, pp;
  logic pv, perr;
  logic [31:0] pdata;
  logic [31:0] rmem [256];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
`ifdef DMEM_ARB_LOCK_EN
    .lock0_i(lock0), .lock1_i(lock1),
`endif
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .err0_o(err0), .err1_o(err1),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    logic rst;
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic g0, g1, mrd, mwr, rv0, rv1;
    logic [31:0] rd;
    logic er;
  } vec_t;
  vec_t tbl [17];

  function automatic vec_t v(input logic rs, r0, w0, input logic [31:0] a0, d0,
                             input logic r1, w1, input logic [31:0] a1, d1,
                             input logic g0, g1, mrd, mwr, rv0, rv1,
                             input logic [31:0] rd, input logic er);
    vec_t x;
    x.rst = rs; x.r0 = r0; x.w0 = w0; x.a0 = a0; x.d0 = d0;
    x.r1 = r1; x.w1 = w1; x.a1 = a1; x.d1 = d1;
    x.g0 = g0; x.g1 = g1; x.mrd = mrd; x.mwr = mwr; x.rv0 = rv0; x.rv1 = rv1;
    x.rd = rd; x.er = er;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: plain round-robin rule, word array memory and one pending response.
  task automatic model_step();
    int w;
    logic [31:0] a, d;
    logic wr, ok, v0, v1;
    w = -1;
    if (!rst) begin
      if (req0 && req1) w = 1 - mlast;
      else if (req0) w = 0;
      else if (req1) w = 1;
    end
    a = (w == 1) ? addr1 : addr0;
    d = (w == 1) ? wdata1 : wdata0;
    wr = (w == 1) ? we1 : we0;
    ok = (a / 4) < 256;
    v0 = !rst && pv && pp == 0;
    v1 = !rst && pv && pp == 1;
    if (chk_model) begin
      chk("m_gnt0", {31'b0, gnt0}, {31'b0, w == 0});
      chk("m_gnt1", {31'b0, gnt1}, {31'b0, w == 1});
      chk("m_mem_read", {31'b0, mem_read}, {31'b0, w >= 0 && !wr && ok});
      chk("m_mem_write", {31'b0, mem_write}, {31'b0, w >= 0 && wr && ok});
      chk("m_rvalid0", {31'b0, rvalid0}, {31'b0, v0});
      chk("m_rvalid1", {31'b0, rvalid1}, {31'b0, v1});
      chk("m_rdata0", rdata0, v0 ? pdata : 32'h0);
      chk("m_rdata1", rdata1, v1 ? pdata : 32'h0);
      chk("m_err0", {31'b0, err0}, {31'b0, v0 && perr});
      chk("m_err1", {31'b0, err1}, {31'b0, v1 && perr});
    end
    if (rst) begin
      pv = 1'b0;
      mlast = 1;
    end else begin
      pv = w >= 0;
      pp = w;
      perr = w >= 0 && !ok;
      pdata = (w >= 0 && !wr && ok) ? rmem[a[9:2]] : 32'h0;
      if (w >= 0 && wr && ok) rmem[a[9:2]] = d;
      if (w >= 0) mlast = w;
    end
    mw = w;
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  initial begin
    logic h0, h1;
    h0 = 0; h1 = 0;
    for (int i = 0; i < 256; i++) rmem[i] = '0;
    mlast = 1; pv = 0; pp = 0; perr = 0; pdata = 0; mw = -1;
    chk_model = 1;
    idle_in();
    rst = 1; mem_clr = 1;
    req0 = 1; req1 = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", {30'b0, gnt1, gnt0}, 32'h0);
      chk("rst_mem_ctl", {30'b0, mem_write, mem_read}, 32'h0);
      chk("rst_rsp", {rdata0 | rdata1} | {28'b0, rvalid0, rvalid1, err0, err1}, 32'h0);
      adv();
    end
    mem_clr = 0;
    rst = 0;
    idle_in();

    tbl[0]  = v(F, T, T, 32'h10, 32'hDEADBEEF, F, F, 32'h0, 32'h0,          T, F, F, T, F, F, 32'h0, F);
    tbl[1]  = v(F, T, F, 32'h10, 32'h0,        F, F, 32'h0, 32'h0,          T, F, T, F, T, F, 32'h0, F);
    tbl[2]  = v(F, F, F, 32'h0,  32'h0,        F, F, 32'h0, 32'h0,          F, F, F, F, T, F, 32'hDEADBEEF, F);
    tbl[3]  = v(T, F, F, 32'h0,  32'h0,        F, F, 32'h0, 32'h0,          F, F, F, F, F, F, 32'h0, F);
    tbl[4]  = v(F, T, F, 32'h10, 32'h0,        T, F, 32'h10, 32'h0,         T, F, T, F, F, F, 32'h0, F);
    tbl[5]  = v(F, T, F, 32'h10, 32'h0,        T, F, 32'h10, 32'h0,         F, T, T, F, T, F, 32'hDEADBEEF, F);
    tbl[6]  = v(F, T, F, 32'h10, 32'h0,        T, F, 32'h10, 32'h0,         T, F, T, F, F, T, 32'hDEADBEEF, F);
    tbl[7]  = v(F, F, F, 32'h0,  32'h0,        F, F, 32'h0, 32'h0,          F, F, F, F, T, F, 32'hDEADBEEF, F);
    tbl[8]  = v(F, T, F, 32'h20, 32'h0,        T, T, 32'h20, 32'h5,         F, T, F, T, F, F, 32'h0, F);
    tbl[9]  = v(F, T, F, 32'h20, 32'h0,        F, F, 32'h0, 32'h0,          T, F, T, F, F, T, 32'h0, F);
    tbl[10] = v(F, F, F, 32'h0,  32'h0,        F, F, 32'h0, 32'h0,          F, F, F, F, T, F, 32'h5, F);
    tbl[11] = v(F, T, F, 32'h400, 32'h0,       F, F, 32'h0, 32'h0,          T, F, F, F, F, F, 32'h0, F);
    tbl[12] = v(F, F, F, 32'h0,  32'h0,        F, F, 32'h0, 32'h0,          F, F, F, F, T, F, 32'h0, T);
    tbl[13] = v(F, T, F, 32'h10, 32'h0,        F, F, 32'h0, 32'h0,          T, F, T, F, F, F, 32'h0, F);
    tbl[14] = v(T, T, F, 32'h10, 32'h0,        T, T, 32'h10, 32'h1234,      F, F, F, F, F, F, 32'h0, F);
    tbl[15] = v(F, T, F, 32'h10, 32'h0,        T, F, 32'h10, 32'h0,         T, F, T, F, F, F, 32'h0, F);
    tbl[16] = v(F, F, F, 32'h0,  32'h0,        F, F, 32'h0, 32'h0,          F, F, F, F, T, F, 32'hDEADBEEF, F);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {30'b0, gnt1, gnt0}, {30'b0, tbl[i].g1, tbl[i].g0});
      chk($sformatf("v%0d_mem_ctl", i), {30'b0, mem_write, mem_read}, {30'b0, tbl[i].mwr, tbl[i].mrd});
      chk($sformatf("v%0d_rvalid", i), {30'b0, rvalid1, rvalid0}, {30'b0, tbl[i].rv1, tbl[i].rv0});
      chk($sformatf("v%0d_rdata0", i), rdata0, tbl[i].rv0 ? tbl[i].rd : 32'h0);
      chk($sformatf("v%0d_rdata1", i), rdata1, tbl[i].rv1 ? tbl[i].rd : 32'h0);
      chk($sformatf("v%0d_err", i), {30'b0, err1, err0}, {30'b0, tbl[i].rv1 & tbl[i].er, tbl[i].rv0 & tbl[i].er});
      adv();
    end
    rst = 0;
    idle_in();

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!h0) begin
        req0 = ($urandom_range(0, 9) < 6);
        we0 = $urandom_range(0, 1) == 1;
        addr0 = 32'($urandom_range(0, 300)) << 2;
        wdata0 = $urandom;
      end
      if (!h1) begin
        req1 = ($urandom_range(0, 9) < 6);
        we1 = $urandom_range(0, 1) == 1;
        addr1 = 32'($urandom_range(0, 300)) << 2;
        wdata1 = $urandom;
      end
      @(negedge clk);
      adv();
      h0 = req0 && mw != 0;
      h1 = req1 && mw != 1;
    end
    rst = 0;
    idle_in();
    @(negedge clk);
    adv();

`ifdef DMEM_ARB_LOCK_EN
    chk_model = 0;
    rst = 1;
    @(negedge clk);
    adv();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      req0 = 1; we0 = 0; addr0 = 32'h10;
      req1 = (k < 5); we1 = 0; addr1 = 32'h14; lock1 = (k < 5);
      @(negedge clk);
      chk($sformatf("lock%0d_gnt0", k), {31'b0, gnt0}, {31'b0, k == 0 || k == 5});
      chk($sformatf("lock%0d_gnt1", k), {31'b0, gnt1}, {31'b0, k >= 1 && k <= 4});
      adv();
    end
    idle_in();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
